linepack: RTL and testbench



---
 rtl/linepack_pkg.sv | 19 +
 rtl/linepack_acc.sv | 52 +++++
 rtl/linepack.sv | 170 +++++++++++++++++
 tb/tb_linepack.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/linepack_pkg.sv
// Shared line geometry and state encodings for the line-FIFO packer.
// The detector imports the same geometry so both ends agree on words per line.
package linepack_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PACK = 2'd1,
      ST_PAD  = 2'd2,
      ST_SKIP = 2'd3
   } state_e;

   localparam int PixPerWord      = 16;
   localparam int WordsPerLineDef = 21;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/linepack_acc.sv
// Byte-lane accumulator: collects pixels into a 128-bit word, lane index in pixidx.
// word_o is the word as it would be with pix_i placed at the current lane.
module linepack_acc
   import linepack_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic         wr_i,
   input  logic [7:0]   pix_i,
   output logic         last_o,
   output logic [127:0] word_o
);

   localparam logic [3:0] LastIdx = 4'(PixPerWord - 1);

   logic [127:0] acc_q, acc_d;
   logic [3:0]   idx_q, idx_d;

   always_comb begin
      word_o = acc_q;
      word_o[{idx_q, 3'b000} +: 8] = pix_i;
   end

   assign last_o = (idx_q == LastIdx);

   always_comb begin
      acc_d = acc_q;
      idx_d = idx_q;
      if (start_i) begin
         acc_d[7:0] = pix_i;
         idx_d      = 4'd1;
      end else if (wr_i) begin
         acc_d = word_o;
         idx_d = idx_q + 4'd1;
      end else begin
         acc_d = acc_q;
         idx_d = idx_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q <= 128'd0;
         idx_q <= 4'd0;
      end else begin
         acc_q <= acc_d;
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/linepack.sv
// Packs 8-bit pixels into 128-bit words and writes exactly WordsPerLine words per
// line to the line FIFO, zero-padding aborted or overflowed lines.
module linepack
   import linepack_pkg::*;
#(
   parameter int WordsPerLine = WordsPerLineDef
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   pixdata,
   input  logic         pixvalid,
   input  logic         linestart,
   input  logic         wrfull,
   output logic         wrfifo,
   output logic [127:0] wrdata,
   output logic [15:0]  linecount,
   output logic [15:0]  dropcount,
   output logic [1:0]   stateoutput
);

   localparam logic [7:0] WplFull = 8'(WordsPerLine);
   localparam logic [7:0] WplLast = 8'(WordsPerLine - 1);

   state_e        state_q, state_d;
   logic [127:0]  wrdata_q, wrdata_d;
   logic          pending_q, pending_d;
   logic [7:0]    wordcnt_q, wordcnt_d;
   logic [15:0]   linecount_q, linecount_d;
   logic [15:0]   dropcount_q, dropcount_d;
   logic          skipnext_q, skipnext_d;

   logic          wr_s, can_load_s, pix_ls_s, pix_nls_s;
   logic          acc_start_s, acc_wr_s, acc_last_s;
   logic [127:0]  acc_word_s;
   logic          load_data_s, load_zero_s, clr_wordcnt_s;
   logic          inc_line_s, inc_drop_s, set_skip_s, clr_skip_s;

   assign wr_s       = pending_q & ~wrfull;
   // A word may load when the slot is free or is being emptied at this same edge.
   assign can_load_s = ~pending_q | wr_s;
   assign pix_ls_s   = pixvalid & linestart;
   assign pix_nls_s  = pixvalid & ~linestart;

   linepack_acc u_acc (
      .clk_i   (clk),
      .rst_i   (reset),
      .start_i (acc_start_s),
      .wr_i    (acc_wr_s),
      .pix_i   (pixdata),
      .last_o  (acc_last_s),
      .word_o  (acc_word_s)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      acc_start_s   = 1'b0;
      acc_wr_s      = 1'b0;
      load_data_s   = 1'b0;
      load_zero_s   = 1'b0;
      clr_wordcnt_s = 1'b0;
      inc_line_s    = 1'b0;
      inc_drop_s    = 1'b0;
      set_skip_s    = 1'b0;
      clr_skip_s    = 1'b0;
      case (state_q)
         ST_IDLE, ST_SKIP: begin
            if (pix_ls_s) begin
               acc_start_s   = 1'b1;
               clr_wordcnt_s = 1'b1;
               state_d       = ST_PACK;
            end else begin
               state_d = state_q;
            end
         end
         ST_PACK: begin
            if (pix_ls_s) begin
               inc_drop_s = 1'b1;
               set_skip_s = 1'b1;
               state_d    = ST_PAD;
            end else if (pix_nls_s) begin
               acc_wr_s = 1'b1;
               if (acc_last_s && can_load_s) begin
                  load_data_s = 1'b1;
                  if (wordcnt_q == WplLast) begin
                     inc_line_s = 1'b1;
                     state_d    = ST_IDLE;
                  end else begin
                     state_d = ST_PACK;
                  end
               end else if (acc_last_s) begin
                  inc_drop_s = 1'b1;
                  state_d    = ST_PAD;
               end else begin
                  state_d = ST_PACK;
               end
            end else begin
               state_d = ST_PACK;
            end
         end
         ST_PAD: begin
            if (wordcnt_q == WplFull) begin
               clr_skip_s = 1'b1;
               if (skipnext_q || pix_ls_s) begin
                  inc_drop_s = 1'b1;
                  state_d    = ST_SKIP;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               set_skip_s  = pix_ls_s;
               load_zero_s = can_load_s;
               state_d     = ST_PAD;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      wrfifo      = wr_s;
      stateoutput = state_q;
      wrdata      = wrdata_q;
      linecount   = linecount_q;
      dropcount   = dropcount_q;
   end

   always_comb begin
      wrdata_d    = wrdata_q;
      pending_d   = pending_q;
      wordcnt_d   = wordcnt_q;
      linecount_d = inc_line_s ? sat_inc16(linecount_q) : linecount_q;
      dropcount_d = inc_drop_s ? sat_inc16(dropcount_q) : dropcount_q;
      skipnext_d  = set_skip_s ? 1'b1 : (clr_skip_s ? 1'b0 : skipnext_q);
      if (load_data_s || load_zero_s) begin
         wrdata_d  = load_data_s ? acc_word_s : 128'd0;
         pending_d = 1'b1;
         wordcnt_d = wordcnt_q + 8'd1;
      end else if (wr_s) begin
         pending_d = 1'b0;
      end else begin
         pending_d = pending_q;
      end
      if (clr_wordcnt_s) wordcnt_d = 8'd0;
      else               wordcnt_d = wordcnt_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrdata_q    <= 128'd0;
         pending_q   <= 1'b0;
         wordcnt_q   <= 8'd0;
         linecount_q <= 16'd0;
         dropcount_q <= 16'd0;
         skipnext_q  <= 1'b0;
      end else begin
         wrdata_q    <= wrdata_d;
         pending_q   <= pending_d;
         wordcnt_q   <= wordcnt_d;
         linecount_q <= linecount_d;
         dropcount_q <= dropcount_d;
         skipnext_q  <= skipnext_d;
      end
   end

endmodule

// File: tb/tb_linepack.sv
// Directed bench for linepack: ramp lines, back-pressure, overflow, short line,
// stray pixels and mid-line reset, with expected words computed from the ramp.
module tb_linepack;

   logic         clk = 1'b0;
   logic         reset;
   logic [7:0]   pixdata;
   logic         pixvalid, linestart, wrfull;
   logic         wrfifo;
   logic [127:0] wrdata;
   logic [15:0]  linecount, dropcount;
   logic [1:0]   stateoutput;

   int errors = 0;
   int checks = 0;
   int viol   = 0;
   logic [127:0] wq [$];
   int base;

   always #5 clk = ~clk;

   linepack #(.WordsPerLine(21)) dut (
      .clk(clk), .reset(reset), .pixdata(pixdata), .pixvalid(pixvalid),
      .linestart(linestart), .wrfull(wrfull), .wrfifo(wrfifo), .wrdata(wrdata),
      .linecount(linecount), .dropcount(dropcount), .stateoutput(stateoutput)
   );

   // Inputs are stable at the falling edge, so a high wrfifo here is a write at the next edge.
   always @(negedge clk) begin
      if (!reset && wrfifo) begin
         wq.push_back(wrdata);
         if (wrfull) viol++;
      end
   end

   function automatic logic [127:0] ramp_word(input int k);
      logic [127:0] w;
      for (int j = 0; j < 16; j++) w[8*j +: 8] = 8'((16*k + j) % 256);
      return w;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pix(input logic v, input logic ls, input logic [7:0] d, input logic f);
      pixvalid  = v;
      linestart = ls;
      pixdata   = d;
      wrfull    = f;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) pix(1'b0, 1'b0, 8'd0, 1'b0);
   endtask

   initial begin
      reset = 1'b1; pixvalid = 1'b0; linestart = 1'b0; pixdata = 8'd0; wrfull = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wrfifo", 128'(wrfifo), 128'd0);
      chk("rst_wrdata", wrdata, 128'd0);
      chk("rst_linecount", 128'(linecount), 128'd0);
      chk("rst_dropcount", 128'(dropcount), 128'd0);
      chk("rst_state", 128'(stateoutput), 128'd0);
      reset = 1'b0;
      idle(2);

      // Plain ramp line
      base = wq.size();
      for (int i = 0; i < 16; i++) pix(1'b1, i == 0, 8'(i), 1'b0);
      chk("lat_wrfifo", 128'(wrfifo), 128'd1);
      chk("lat_wrdata", wrdata, 128'h0F0E0D0C0B0A09080706050403020100);
      for (int i = 16; i < 336; i++) pix(1'b1, 1'b0, 8'(i), 1'b0);
      idle(4);
      chk("ramp_writes", 128'(wq.size() - base), 128'd21);
      for (int k = 0; k < 21; k++) chk($sformatf("ramp_word%0d", k), wq[base + k], ramp_word(k));
      chk("ramp_linecount", 128'(linecount), 128'd1);
      chk("ramp_dropcount", 128'(dropcount), 128'd0);

      // Back-pressure: word 1 held for 10 cycles
      base = wq.size();
      for (int i = 0; i < 336; i++) begin
         pix(1'b1, i == 0, 8'(i), (i >= 32 && i < 42));
         if (i == 36) begin
            chk("hold_wrfifo", 128'(wrfifo), 128'd0);
            chk("hold_wrdata", wrdata, ramp_word(1));
         end
      end
      idle(4);
      chk("bp_writes", 128'(wq.size() - base), 128'd21);
      chk("bp_word1", wq[base + 1], ramp_word(1));
      chk("bp_word20", wq[base + 20], ramp_word(20));
      chk("bp_linecount", 128'(linecount), 128'd2);
      chk("bp_dropcount", 128'(dropcount), 128'd0);

      // Overflow: wrfull high for 40 cycles
      base = wq.size();
      for (int i = 0; i < 336; i++) begin
         pix(1'b1, i == 0, 8'(i), (i >= 20 && i < 60));
         if (i == 47) begin
            chk("ovf_state", 128'(stateoutput), 128'd2);
            chk("ovf_dropcount", 128'(dropcount), 128'd1);
         end
      end
      idle(4);
      chk("ovf_writes", 128'(wq.size() - base), 128'd21);
      chk("ovf_word1", wq[base + 1], ramp_word(1));
      chk("ovf_word2", wq[base + 2], 128'd0);
      chk("ovf_word20", wq[base + 20], 128'd0);
      chk("ovf_linecount", 128'(linecount), 128'd2);
      base = wq.size();
      for (int i = 0; i < 336; i++) pix(1'b1, i == 0, 8'(i), 1'b0);
      idle(4);
      chk("post_ovf_writes", 128'(wq.size() - base), 128'd21);
      chk("post_ovf_word5", wq[base + 5], ramp_word(5));
      chk("post_ovf_linecount", 128'(linecount), 128'd3);

      // Short line: second linestart after 100 pixels, that line is skipped
      base = wq.size();
      for (int i = 0; i < 100; i++) pix(1'b1, i == 0, 8'(i), 1'b0);
      for (int i = 0; i < 336; i++) pix(1'b1, i == 0, 8'(i), 1'b0);
      idle(2);
      chk("short_writes", 128'(wq.size() - base), 128'd21);
      chk("short_word5", wq[base + 5], ramp_word(5));
      chk("short_word6", wq[base + 6], 128'd0);
      chk("short_word20", wq[base + 20], 128'd0);
      chk("short_dropcount", 128'(dropcount), 128'd3);
      chk("short_state_skip", 128'(stateoutput), 128'd3);
      base = wq.size();
      for (int i = 0; i < 336; i++) pix(1'b1, i == 0, 8'(i), 1'b0);
      idle(4);
      chk("after_skip_writes", 128'(wq.size() - base), 128'd21);
      chk("after_skip_word0", wq[base], ramp_word(0));
      chk("after_skip_linecount", 128'(linecount), 128'd4);

      // Stray pixels in Idle
      base = wq.size();
      for (int i = 0; i < 20; i++) pix(1'b1, 1'b0, 8'(i + 7), 1'b0);
      idle(3);
      chk("stray_writes", 128'(wq.size() - base), 128'd0);
      chk("stray_linecount", 128'(linecount), 128'd4);
      chk("stray_dropcount", 128'(dropcount), 128'd3);
      chk("stray_state", 128'(stateoutput), 128'd0);

      // Reset mid-line with a pending word
      for (int i = 0; i < 16; i++) pix(1'b1, i == 0, 8'(i), 1'b0);
      chk("pre_rst_wrfifo", 128'(wrfifo), 128'd1);
      reset = 1'b1;
      #1;
      chk("midrst_wrfifo", 128'(wrfifo), 128'd0);
      chk("midrst_wrdata", wrdata, 128'd0);
      chk("midrst_linecount", 128'(linecount), 128'd0);
      chk("midrst_dropcount", 128'(dropcount), 128'd0);
      chk("midrst_state", 128'(stateoutput), 128'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle(2);
      base = wq.size();
      for (int i = 0; i < 336; i++) pix(1'b1, i == 0, 8'(i + 3), 1'b0);
      idle(4);
      chk("rst_line_writes", 128'(wq.size() - base), 128'd21);
      chk("rst_line_word0", wq[base], 128'h1211100F0E0D0C0B0A09080706050403);
      chk("rst_line_linecount", 128'(linecount), 128'd1);
      chk("rst_line_dropcount", 128'(dropcount), 128'd0);
      chk("no_write_when_full", 128'(viol), 128'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
